// File: rtl/alu_logic_arbiter.sv
// Round-robin arbiter that time-shares one external bitwise logic unit between
// two requesters and returns each result through a registered valid/ready port.
module alu_logic_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_a,
  output logic             req_ready_a,
  input  logic [1:0]       req_op_a,
  input  logic [WIDTH-1:0] req_op1_a,
  input  logic [WIDTH-1:0] req_op2_a,
  input  logic             req_valid_b,
  output logic             req_ready_b,
  input  logic [1:0]       req_op_b,
  input  logic [WIDTH-1:0] req_op1_b,
  input  logic [WIDTH-1:0] req_op2_b,
  output logic [1:0]       lu_sel,
  output logic [WIDTH-1:0] lu_op1,
  output logic [WIDTH-1:0] lu_op2,
  input  logic [WIDTH-1:0] lu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_zero,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;  // 0 = A, 1 = B
  logic [1:0]       op_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic             id_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Requesters hold valid/op/operands until accepted and never derive valid
  // from ready; readies are only raised in IDLE, and the loser of a
  // contention is the side that was granted most recently.
  assign req_ready_a = (state == IDLE) && req_valid_a && (!req_valid_b || last_grant);
  assign req_ready_b = (state == IDLE) && req_valid_b && (!req_valid_a || !last_grant);

  assign lu_sel    = op_q;
  assign lu_op1    = op1_q;
  assign lu_op2    = op2_q;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_zero  = (rsp_data == '0);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      id_q       <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ready_a) begin
            op_q       <= req_op_a;
            op1_q      <= req_op1_a;
            op2_q      <= req_op2_a;
            id_q       <= 1'b0;
            last_grant <= 1'b0;
            state      <= EXEC;
          end else if (req_ready_b) begin
            op_q       <= req_op_b;
            op1_q      <= req_op1_b;
            op2_q      <= req_op2_b;
            id_q       <= 1'b1;
            last_grant <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data <= lu_out;
          state    <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Bench for alu_logic_arbiter: directed scenarios plus randomized two-requester
// traffic, scored against a transaction-level model of the arbiter.
module tb_alu_logic_arbiter;

  logic       clk;
  logic       rst;
  logic       req_valid_a, req_valid_b;
  logic       req_ready_a, req_ready_b;
  logic [1:0] req_op_a, req_op_b;
  logic [7:0] req_op1_a, req_op2_a, req_op1_b, req_op2_b;
  logic [1:0] lu_sel;
  logic [7:0] lu_op1, lu_op2, lu_out;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_id, rsp_zero, busy;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  alu_logic_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_ready_a(req_ready_a),
    .req_op_a(req_op_a), .req_op1_a(req_op1_a), .req_op2_a(req_op2_a),
    .req_valid_b(req_valid_b), .req_ready_b(req_ready_b),
    .req_op_b(req_op_b), .req_op1_b(req_op1_b), .req_op2_b(req_op2_b),
    .lu_sel(lu_sel), .lu_op1(lu_op1), .lu_op2(lu_op2), .lu_out(lu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_zero(rsp_zero), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // External logic unit stand-in.
  always_comb begin
    case (lu_sel)
      2'd0:    lu_out = lu_op1 & lu_op2;
      2'd1:    lu_out = lu_op1 | lu_op2;
      2'd2:    lu_out = lu_op1 ^ lu_op2;
      default: lu_out = ~(lu_op1 ^ lu_op2);
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic       id;
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] r;
  } ent_t;

  ent_t exp_q[$];
  bit   mon_en = 0;
  bit   m_out  = 0;   // an operation is in flight
  int   m_age  = 0;   // cycles since accept (1 = EXEC cycle)
  bit   m_last_b = 1;

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int ones;
      ones = int'(x[i]) + int'(y[i]);
      case (op)
        2'd0: r[i] = (ones == 2);
        2'd1: r[i] = (ones >= 1);
        2'd2: r[i] = (ones == 1);
        default: r[i] = (ones != 1);
      endcase
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic e_ra, e_rb, e_rv;
    logic [1:0] e_st;
    ent_t e;
    if (rst) begin
      m_out = 0; m_age = 0; m_last_b = 1;
      exp_q.delete();
    end else if (mon_en) begin
      e_ra = !m_out && req_valid_a && (!req_valid_b || m_last_b);
      e_rb = !m_out && req_valid_b && (!req_valid_a || !m_last_b);
      e_rv = m_out && (m_age >= 2);
      e_st = !m_out ? 2'd0 : (m_age == 1 ? 2'd1 : 2'd2);
      check("ready_a", req_ready_a, e_ra);
      check("ready_b", req_ready_b, e_rb);
      check("busy", busy, m_out);
      check("rsp_valid", rsp_valid, e_rv);
      check("state", dbg_state, e_st);
      if (m_out && exp_q.size() > 0) begin
        e = exp_q[0];
        if (m_age == 1) begin
          check("lu_sel", lu_sel, e.op);
          check("lu_op1", lu_op1, e.x);
          check("lu_op2", lu_op2, e.y);
        end else begin
          check("rsp_data", rsp_data, e.r);
          check("rsp_id", rsp_id, e.id);
          check("rsp_zero", rsp_zero, e.r == 8'h00);
        end
      end
      // advance model to the next cycle
      if (e_ra || e_rb) begin
        e.id = e_rb;
        e.op = e_rb ? req_op_b : req_op_a;
        e.x  = e_rb ? req_op1_b : req_op1_a;
        e.y  = e_rb ? req_op2_b : req_op2_a;
        e.r  = ref_result(e.op, e.x, e.y);
        exp_q.push_back(e);
        m_last_b = e_rb;
        m_out = 1; m_age = 1;
      end else if (m_out) begin
        if (m_age >= 2 && rsp_ready) begin
          m_out = 0;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (m_age < 2) begin
          m_age++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    req_valid_a = 1; req_op_a = op; req_op1_a = x; req_op2_a = y;
    @(negedge clk);
    while (!req_ready_a && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("accept_a_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid_a = 0;
  endtask

  task automatic send_b(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    req_valid_b = 1; req_op_b = op; req_op1_b = x; req_op2_b = y;
    @(negedge clk);
    while (!req_ready_b && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check("accept_b_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid_b = 0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("rsp_timeout", 1, 0);
  endtask

  task automatic expect_rsp(input logic [7:0] d, input logic id);
    int n = 0;
    wait_rsp();
    check("exp_data", rsp_data, d);
    check("exp_id", rsp_id, id);
    check("exp_zero", rsp_zero, d == 8'h00);
    while (!rsp_ready && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // ---------------- stimulus ----------------
  bit rand_rdy = 0;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    rst = 1; rsp_ready = 0;
    req_valid_a = 0; req_op_a = 0; req_op1_a = 0; req_op2_a = 0;
    req_valid_b = 0; req_op_b = 0; req_op1_b = 0; req_op2_b = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    mon_en = 1;

    // 1: reset values
    @(negedge clk);
    check("rst_state", dbg_state, 2'd0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lu_sel", lu_sel, 0);
    check("rst_lu_op1", lu_op1, 0);
    check("rst_lu_op2", lu_op2, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    @(posedge clk); #1;

    // 2: A XNOR
    rsp_ready = 1;
    send_a(2'd3, 8'hAA, 8'hAA);
    expect_rsp(8'hFF, 1'b0);

    // 3: B XNOR then AND
    send_b(2'd3, 8'hF0, 8'h0F);
    expect_rsp(8'h00, 1'b1);
    send_b(2'd0, 8'hF0, 8'h3C);
    expect_rsp(8'h30, 1'b1);

    // 4: contention right after reset, then a fresh pair
    do_reset();
    fork
      send_a(2'd2, 8'h0F, 8'hFF);
      send_b(2'd1, 8'h01, 8'h80);
      begin expect_rsp(8'hF0, 1'b0); expect_rsp(8'h81, 1'b1); end
    join
    fork
      send_a(2'd0, 8'hFF, 8'h0F);
      send_b(2'd2, 8'h33, 8'h30);
      begin expect_rsp(8'h0F, 1'b0); expect_rsp(8'h03, 1'b1); end
    join

    // 5: backpressure with B pending
    rsp_ready = 0;
    fork
      send_a(2'd1, 8'h12, 8'h40);
      send_b(2'd3, 8'h55, 8'hAA);
      begin
        wait_rsp();
        repeat (3) begin
          check("bp_valid", rsp_valid, 1);
          check("bp_data", rsp_data, 8'h52);
          check("bp_id", rsp_id, 0);
          check("bp_ready_b", req_ready_b, 0);
          @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle", dbg_state, 2'd0);
        check("bp_accept_b", req_ready_b, 1);
        expect_rsp(8'h00, 1'b1);
      end
    join

    // 6: reset during EXEC discards the operation
    send_a(2'd1, 8'h0F, 8'hF0);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("rx_state", dbg_state, 2'd0);
    check("rx_rsp_valid", rsp_valid, 0);
    repeat (3) @(negedge clk);
    check("rx_no_rsp", rsp_valid, 0);
    @(posedge clk); #1;
    fork
      send_a(2'd2, 8'hC3, 8'h3C);
      send_b(2'd0, 8'hC3, 8'h3C);
      begin expect_rsp(8'hFF, 1'b0); expect_rsp(8'h00, 1'b1); end
    join

    // random traffic with random backpressure
    rand_rdy = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        send_a(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      for (int i = 0; i < 40; i++) begin
        send_b(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
    join
    rand_rdy = 0;
    @(posedge clk); #1 rsp_ready = 1;
    for (int n = 0; n < 50 && (m_out || exp_q.size() > 0); n++) @(posedge clk);
    check("drain_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
